// File: rtl/mem_req_seq_pkg.sv
// Shared types and constants for the memory request sequencer.
package mem_req_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    IFETCH,
    WAIT_CMP,
    WRES,
    DONE
  } state_t;

  localparam logic [1:0] REG_SEL_IMG_ADDR    = 2'b00;
  localparam logic [1:0] REG_SEL_IMG_CNT     = 2'b01;
  localparam logic [1:0] REG_SEL_RSLT_ADDR   = 2'b10;
  localparam logic [1:0] REG_SEL_WEIGHT_ADDR = 2'b11;

  localparam int ADDR_W = 28;

  // Bits needed to hold values 0..n inclusive (at least 1).
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_req_sequencer_credit.sv
// req_credit_cnt: tracks read requests issued but not yet answered.
// A response arriving with nothing outstanding is flagged and dropped.
module req_credit_cnt
  import mem_req_seq_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty,
  output logic underflow
);

  localparam int CW = cnt_width(MAX_OUTSTANDING);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  assign empty     = (cnt_reg == '0);
  assign full      = (cnt_reg == MAX_C);
  assign underflow = dec && !inc && empty && !clr;

  // Next count: simultaneous issue and response cancel out.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && !dec) begin
      cnt_next = cnt_reg + 1'b1;
    end else if (dec && !inc && !empty) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer: drives the address/count register block strobes and
// the memory request port. Per job: weight load, then per image a block
// fetch, wait for compute, and a single result write.
// Optional stall timeout: define MEM_REQ_SEQ_TIMEOUT_EN.
module mem_req_sequencer
  import mem_req_seq_pkg::*;
#(
  parameter int WEIGHT_WORDS    = 64,
  parameter int BLOCKS_PER_IMG  = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] img_total,
  input  logic              host_wr_active,
  input  logic              compute_done,
  output logic [1:0]        rd_reg_sel,
  input  logic [31:0]       reg_rd_data,
  output logic              inc_img_addr,
  output logic              inc_img_cnt,
  output logic              inc_rslt_addr,
  output logic              inc_weight_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wr,
  input  logic              mem_rsp_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PH_MAX = (WEIGHT_WORDS > BLOCKS_PER_IMG) ? WEIGHT_WORDS : BLOCKS_PER_IMG;
  localparam int PH_W   = cnt_width(PH_MAX);
  localparam logic [PH_W-1:0] W_LAST = PH_W'(WEIGHT_WORDS - 1);
  localparam logic [PH_W-1:0] B_LAST = PH_W'(BLOCKS_PER_IMG - 1);

  state_t              state_reg, state_next;
  logic [PH_W-1:0]     req_cnt_reg, req_cnt_next;
  logic [ADDR_W-1:0]   img_total_reg, img_total_next;
  logic [ADDR_W-1:0]   images_done_reg, images_done_next;
  logic                cmp_latch_reg;
  logic                err_reg;

  logic start_acc;
  logic cmp_clr;
  logic hs;
  logic rd_hs;
  logic credit_full, credit_empty, credit_underflow;
  logic timeout;
  logic ign_rsp;

  assign mem_req_addr = reg_rd_data[ADDR_W-1:0];
  assign hs           = mem_req_valid && mem_req_ready;
  assign rd_hs        = hs && !mem_req_wr;
  assign busy         = (state_reg == WLOAD) || (state_reg == IFETCH) ||
                        (state_reg == WAIT_CMP) || (state_reg == WRES);
  assign done         = (state_reg == DONE);
  assign err          = err_reg;

  req_credit_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (timeout),
    .inc      (rd_hs),
    .dec      (mem_rsp_valid && !ign_rsp),
    .full     (credit_full),
    .empty    (credit_empty),
    .underflow(credit_underflow)
  );

`ifdef MEM_REQ_SEQ_TIMEOUT_EN
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] stall_cnt_reg;
  logic          ign_rsp_reg;
  logic          unused_rd_hi;

  assign unused_rd_hi = ^reg_rd_data[31:ADDR_W];
  assign timeout = mem_req_valid && !mem_req_ready && (stall_cnt_reg == T_LAST);
  assign ign_rsp = ign_rsp_reg;

  // Stall counter and post-timeout response squelch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      ign_rsp_reg   <= 1'b0;
    end else begin
      if (mem_req_valid && !mem_req_ready && !timeout) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end else begin
        stall_cnt_reg <= '0;
      end
      if (timeout) begin
        ign_rsp_reg <= 1'b1;
      end else if (start_acc) begin
        ign_rsp_reg <= 1'b0;
      end
    end
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = TIMEOUT_CYCLES ^ {28'd0, reg_rd_data[31:ADDR_W]};
  assign timeout = 1'b0;
  assign ign_rsp = 1'b0;
`endif

  // Request port decode: select, direction and gated valid per state.
  always_comb begin
    rd_reg_sel    = REG_SEL_IMG_ADDR;
    mem_req_valid = 1'b0;
    mem_req_wr    = 1'b0;
    case (state_reg)
      WLOAD: begin
        rd_reg_sel    = REG_SEL_WEIGHT_ADDR;
        mem_req_valid = !host_wr_active && !credit_full;
      end
      IFETCH: begin
        rd_reg_sel    = REG_SEL_IMG_ADDR;
        mem_req_valid = !host_wr_active && !credit_full;
      end
      WRES: begin
        rd_reg_sel    = REG_SEL_RSLT_ADDR;
        mem_req_wr    = 1'b1;
        mem_req_valid = !host_wr_active;
      end
      default: begin
        rd_reg_sel = REG_SEL_IMG_ADDR;
      end
    endcase
  end

  // Next state, phase counters and increment strobes.
  always_comb begin
    state_next       = state_reg;
    req_cnt_next     = req_cnt_reg;
    img_total_next   = img_total_reg;
    images_done_next = images_done_reg;
    start_acc        = 1'b0;
    cmp_clr          = 1'b0;
    inc_img_addr     = 1'b0;
    inc_img_cnt      = 1'b0;
    inc_rslt_addr    = 1'b0;
    inc_weight_addr  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          start_acc        = 1'b1;
          img_total_next   = img_total;
          images_done_next = '0;
          req_cnt_next     = '0;
          if (img_total == '0) begin
            state_next = DONE;
          end else if (WEIGHT_WORDS == 0) begin
            state_next = IFETCH;
          end else begin
            state_next = WLOAD;
          end
        end
      end
      WLOAD: begin
        if (hs) begin
          inc_weight_addr = 1'b1;
          if (req_cnt_reg == W_LAST) begin
            req_cnt_next = '0;
            state_next   = IFETCH;
          end else begin
            req_cnt_next = req_cnt_reg + 1'b1;
          end
        end
      end
      IFETCH: begin
        if (hs) begin
          inc_img_addr = 1'b1;
          if (req_cnt_reg == B_LAST) begin
            req_cnt_next = '0;
            state_next   = WAIT_CMP;
          end else begin
            req_cnt_next = req_cnt_reg + 1'b1;
          end
        end
      end
      WAIT_CMP: begin
        if (credit_empty && cmp_latch_reg) begin
          cmp_clr    = 1'b1;
          state_next = WRES;
        end
      end
      WRES: begin
        if (hs) begin
          inc_rslt_addr    = 1'b1;
          inc_img_cnt      = 1'b1;
          images_done_next = images_done_reg + 1'b1;
          if ((images_done_reg + 1'b1) == img_total_reg) begin
            state_next = DONE;
          end else begin
            state_next = IFETCH;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (timeout) begin
      state_next = DONE;
    end
  end

  // State and job bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      req_cnt_reg     <= '0;
      img_total_reg   <= '0;
      images_done_reg <= '0;
    end else begin
      state_reg       <= state_next;
      req_cnt_reg     <= req_cnt_next;
      img_total_reg   <= img_total_next;
      images_done_reg <= images_done_next;
    end
  end

  // Sticky compute-done latch; consumed when the result write is entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_latch_reg <= 1'b0;
    end else if (start_acc || cmp_clr) begin
      cmp_latch_reg <= 1'b0;
    end else if (compute_done && busy) begin
      cmp_latch_reg <= 1'b1;
    end
  end

  // Sticky error: set by stray responses or stall timeout, cleared on start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (credit_underflow || timeout) begin
      err_reg <= 1'b1;
    end else if (start_acc) begin
      err_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Directed bench for mem_req_sequencer with a register-block model,
// a response generator and an expected-request scoreboard.
module tb_mem_req_sequencer;

  localparam int W  = 4;
  localparam int B  = 2;
  localparam int MO = 2;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [27:0] img_total = '0;
  logic        host_wr_active = 1'b0;
  logic        compute_done = 1'b0;
  logic [1:0]  rd_reg_sel;
  logic [31:0] reg_rd_data;
  logic        inc_img_addr, inc_img_cnt, inc_rslt_addr, inc_weight_addr;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [27:0] mem_req_addr;
  logic        mem_req_wr;
  logic        mem_rsp_valid = 1'b0;
  logic        busy, done, err;

  logic        hw_we = 1'b0;
  logic [1:0]  hw_sel = '0;
  logic [27:0] hw_data = '0;
  logic [27:0] regs [4];

  typedef struct packed {
    logic        wr;
    logic [27:0] addr;
    logic [3:0]  strb;
  } req_t;

  req_t exp_q[$];
  req_t cur;
  int   checks = 0;
  int   failures = 0;
  int   cnt [4];
  int   c0 [4];
  int   done_cnt = 0;
  int   pending = 0;
  int   man_req = 0;
  int   man_served = 0;
  bit   auto_rsp = 1'b0;
  logic [27:0] m_w, m_i, m_r;
  logic [27:0] hold_addr;

  always #5 clk = ~clk;

  mem_req_sequencer #(
    .WEIGHT_WORDS(W), .BLOCKS_PER_IMG(B), .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .img_total(img_total),
    .host_wr_active(host_wr_active), .compute_done(compute_done),
    .rd_reg_sel(rd_reg_sel), .reg_rd_data(reg_rd_data),
    .inc_img_addr(inc_img_addr), .inc_img_cnt(inc_img_cnt),
    .inc_rslt_addr(inc_rslt_addr), .inc_weight_addr(inc_weight_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wr(mem_req_wr),
    .mem_rsp_valid(mem_rsp_valid), .busy(busy), .done(done), .err(err)
  );

  // Register block model: host writes win, increments lost during host access.
  assign reg_rd_data = {4'h0, regs[rd_reg_sel]};
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (hw_we) begin
      regs[hw_sel] <= hw_data;
    end else if (!host_wr_active) begin
      if (inc_img_addr)    regs[0] <= regs[0] + 28'd1;
      if (inc_img_cnt)     regs[1] <= regs[1] + 28'd1;
      if (inc_rslt_addr)   regs[2] <= regs[2] + 28'd1;
      if (inc_weight_addr) regs[3] <= regs[3] + 28'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor/responder at the falling edge, return just after the rising edge.
  task automatic cycle();
    logic [3:0] strb;
    logic       raw_hs;
    @(negedge clk);
    strb   = {inc_weight_addr, inc_rslt_addr, inc_img_cnt, inc_img_addr};
    raw_hs = mem_req_valid && mem_req_ready;
    mem_rsp_valid = 1'b0;
    if (man_req != man_served) begin
      mem_rsp_valid = 1'b1;
      man_served++;
      if (pending > 0) pending--;
    end else if (auto_rsp && pending > 0) begin
      mem_rsp_valid = 1'b1;
      pending--;
    end
    if (!rst_n) pending = 0;
    check("strobe_without_handshake", {31'd0, (strb != 4'b0) && !raw_hs}, 32'd0);
    if (raw_hs && rst_n) begin
      if (exp_q.size() == 0) begin
        check("unexpected_request", {3'd0, mem_req_wr, mem_req_addr}, 32'hFFFF_FFFF);
      end else begin
        cur = exp_q.pop_front();
        check("req_addr", {4'd0, mem_req_addr}, {4'd0, cur.addr});
        check("req_wr", {31'd0, mem_req_wr}, {31'd0, cur.wr});
        check("req_strobes", {28'd0, strb}, {28'd0, cur.strb});
        $display("txn %s addr=0x%07h strobes=%b", mem_req_wr ? "WR" : "RD", mem_req_addr, strb);
      end
      if (!mem_req_wr) pending++;
      for (int i = 0; i < 4; i++) if (strb[i]) cnt[i]++;
    end
    if (done && rst_n) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wait_cnt(input int idx, input int target, input string tag);
    for (int k = 0; k < 200 && cnt[idx] < target; k++) cycle();
    check(tag, {31'd0, cnt[idx] >= target}, 32'd1);
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int k = 0; k < 300 && done_cnt < target; k++) cycle();
    check(tag, done_cnt, target);
  endtask

  task automatic preload(input logic [27:0] w, input logic [27:0] i, input logic [27:0] r);
    logic [27:0] vals [3];
    logic [1:0]  sels [3];
    vals = '{w, i, r};
    sels = '{2'b11, 2'b00, 2'b10};
    for (int k = 0; k < 3; k++) begin
      host_wr_active = 1'b1; hw_we = 1'b1; hw_sel = sels[k]; hw_data = vals[k];
      cycle();
    end
    host_wr_active = 1'b0; hw_we = 1'b0;
    m_w = w; m_i = i; m_r = r;
  endtask

  task automatic start_job(input int n);
    for (int k = 0; k < n; k++) begin
      if (k == 0) for (int j = 0; j < W; j++) begin
        exp_q.push_back('{1'b0, m_w, 4'b1000}); m_w++;
      end
      for (int j = 0; j < B; j++) begin
        exp_q.push_back('{1'b0, m_i, 4'b0001}); m_i++;
      end
      exp_q.push_back('{1'b1, m_r, 4'b0110}); m_r++;
    end
    img_total = 28'(n);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic pulse_compute();
    compute_done = 1'b1;
    cycle();
    compute_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {21'd0, rd_reg_sel, inc_img_addr, inc_img_cnt, inc_rslt_addr,
           inc_weight_addr, mem_req_valid, mem_req_wr, busy, done, err}, 32'd0);
    check({tag, "_addr"}, {4'd0, mem_req_addr}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    // Reset state
    wait_cycles(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    cycle();

    // 1: two images, full throughput, immediate responses
    preload(28'h100, 28'h2000, 28'h30000);
    auto_rsp = 1'b1; mem_req_ready = 1'b1;
    c0 = cnt;
    start_job(2);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_cnt(0, c0[0] + 2, "t1_fetch0");
    pulse_compute();
    wait_cnt(0, c0[0] + 4, "t1_fetch1");
    pulse_compute();
    wait_done(1, "t1_done");
    check("t1_weight_incs", cnt[3] - c0[3], W);
    check("t1_img_incs", cnt[0] - c0[0], 2 * B);
    check("t1_rslt_incs", cnt[2] - c0[2], 2);
    check("t1_cnt_incs", cnt[1] - c0[1], 2);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_queue_empty", exp_q.size(), 0);
    cycle();
    check("t1_done_once", done_cnt, 1);
    check("t1_idle", {30'd0, busy, done}, 32'd0);

    // 2: ready low for 5 cycles mid-fetch
    c0 = cnt;
    start_job(1);
    wait_cnt(0, c0[0] + 1, "t2_first_fetch");
    mem_req_ready = 1'b0;
    cycle();
    hold_addr = exp_q[0].addr;
    for (int k = 0; k < 5; k++) begin
      check("t2_stall_valid", {31'd0, mem_req_valid}, 32'd1);
      check("t2_stall_addr", {4'd0, mem_req_addr}, {4'd0, hold_addr});
      check("t2_stall_wr", {31'd0, mem_req_wr}, 32'd0);
      check("t2_stall_incs", cnt[0] - c0[0], 1);
      if (k < 4) cycle();
    end
    mem_req_ready = 1'b1;
    wait_cnt(0, c0[0] + B, "t2_fetch_done");
    pulse_compute();
    wait_done(2, "t2_done");

    // 3: outstanding limit with withheld responses
    auto_rsp = 1'b0;
    c0 = cnt;
    start_job(1);
    wait_cycles(8);
    check("t3_reads_at_limit", cnt[3] - c0[3], MO);
    check("t3_valid_blocked", {31'd0, mem_req_valid}, 32'd0);
    man_req++;
    wait_cycles(6);
    check("t3_one_more", cnt[3] - c0[3], MO + 1);
    check("t3_valid_blocked2", {31'd0, mem_req_valid}, 32'd0);
    auto_rsp = 1'b1;
    wait_cnt(0, c0[0] + B, "t3_fetch_done");
    pulse_compute();
    wait_done(3, "t3_done");

    // 4: host register access during weight load
    c0 = cnt;
    start_job(1);
    wait_cnt(3, c0[3] + 1, "t4_first_weight");
    host_wr_active = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t4_valid_forced_low", {31'd0, mem_req_valid}, 32'd0);
      check("t4_no_progress", cnt[3] - c0[3], 1);
    end
    host_wr_active = 1'b0;
    wait_cnt(0, c0[0] + B, "t4_fetch_done");
    pulse_compute();
    wait_done(4, "t4_done");
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: stray response in idle, then empty job clears err
    auto_rsp = 1'b0;
    wait_cycles(2);
    man_req++;
    wait_cycles(3);
    check("t5_err_set", {31'd0, err}, 32'd1);
    wait_cycles(3);
    check("t5_err_sticky", {31'd0, err}, 32'd1);
    c0 = cnt;
    start_job(0);
    check("t5_done_next", {29'd0, done, busy, err}, 32'd4);
    cycle();
    check("t5_done_pulse_end", {31'd0, done}, 32'd0);
    wait_cycles(3);
    check("t5_no_requests", (cnt[0] + cnt[1] + cnt[2] + cnt[3]) -
          (c0[0] + c0[1] + c0[2] + c0[3]), 0);

`ifdef MEM_REQ_SEQ_TIMEOUT_EN
    // 6a: stall timeout
    auto_rsp = 1'b1; mem_req_ready = 1'b0;
    c0 = cnt;
    start_job(1);
    wait_cycles(TO - 1);
    check("t6_no_early_done", {30'd0, done, err}, 32'd0);
    cycle();
    check("t6_timeout_done_err", {30'd0, done, err}, 32'd3);
    cycle();
    check("t6_valid_dropped", {30'd0, mem_req_valid, busy}, 32'd0);
    check("t6_no_handshake", cnt[3] - c0[3], 0);
    exp_q.delete();
    mem_req_ready = 1'b1;
`endif

    // 6b: reset in the middle of a job
    preload(28'h500, 28'h6000, 28'h70000);
    auto_rsp = 1'b1; mem_req_ready = 1'b1;
    c0 = cnt;
    start_job(2);
    wait_cnt(0, c0[0] + 1, "t6_mid_job");
    rst_n = 1'b0;
    cycle();
    check_all_zero("midjob_reset");
    exp_q.delete();
    rst_n = 1'b1;
    wait_cycles(3);
    check("after_reset_idle", {30'd0, busy, mem_req_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
